// File: rtl/lite16_pkg.sv
// Shared constants for the LITE-16 execute-stage ALU: datapath width,
// ALU operation codes, compare condition codes and shifter modes.
package lite16_pkg;

  localparam int WIDTH = 16;

  // ALU operation codes (fn=0)
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;
  localparam logic [2:0] OP_SRA = 3'd7;

  // Compare condition codes (fn=1)
  localparam logic [2:0] CC_EQ     = 3'd0;
  localparam logic [2:0] CC_NE     = 3'd1;
  localparam logic [2:0] CC_LT     = 3'd2;
  localparam logic [2:0] CC_GE     = 3'd3;
  localparam logic [2:0] CC_LTU    = 3'd4;
  localparam logic [2:0] CC_GEU    = 3'd5;
  localparam logic [2:0] CC_ALWAYS = 3'd6;
  localparam logic [2:0] CC_NEVER  = 3'd7;

  // Shifter modes
  localparam logic [1:0] SH_SLL = 2'd0;
  localparam logic [1:0] SH_SRL = 2'd1;
  localparam logic [1:0] SH_SRA = 2'd2;

endpackage

// File: rtl/lite16_alu_shifter.sv
// Combinational logarithmic barrel shifter: SLL, SRL (zero fill) and
// SRA (sign fill). One stage per shift-amount bit.
module lite16_alu_shifter
  import lite16_pkg::*;
#(
  parameter int SW = 16
) (
  input  logic [SW-1:0]         op1,
  input  logic [$clog2(SW)-1:0] shamt,
  input  logic [1:0]            mode,
  output logic [SW-1:0]         result
);

  localparam int NSTAGE = $clog2(SW);

  logic [SW-1:0] stage [0:NSTAGE];
  logic          shift_left;
  logic          fill_bit;

  assign shift_left = (mode == SH_SLL);
  // Arithmetic right shift replicates the original sign bit into every vacated slot.
  assign fill_bit   = (mode == SH_SRA) ? op1[SW-1] : 1'b0;
  assign stage[0]   = op1;

  genvar gi;
  generate
    for (gi = 0; gi < NSTAGE; gi++) begin : g_stage
      localparam int SH = 1 << gi;
      assign stage[gi+1] = !shamt[gi] ? stage[gi] :
                           shift_left ? {stage[gi][SW-1-SH:0], {SH{1'b0}}} :
                                        {{SH{fill_bit}}, stage[gi][SW-1:SH]};
    end
  endgenerate

  assign result = stage[NSTAGE];

endmodule

// File: rtl/lite16_alu.sv
// LITE-16 execute-stage ALU: operand select, add/sub, logic ops, shifts,
// compare conditions and load pass-through, with registered result and flag.
module lite16_alu
  import lite16_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       codeop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] rd,
  input  logic             ri,
  input  logic             ld,
  input  logic             fn,
  output logic [WIDTH-1:0] r,
  output logic             cmp
);

  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             is_eq;
  logic             is_lt;
  logic             is_ltu;
  logic [1:0]       sh_mode;
  logic [WIDTH-1:0] sh_result;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] r_next;
  logic             cmp_reg;
  logic             cmp_next;

  assign op1 = ri ? rd : a;
  assign op2 = b;

  // Shared subtractor: the extra top bit is the unsigned borrow.
  assign sum      = op1 + op2;
  assign diff_ext = {1'b0, op1} - {1'b0, op2};
  assign diff     = diff_ext[WIDTH-1:0];
  assign borrow   = diff_ext[WIDTH];

  // Signed less-than: differing signs decide directly, otherwise the
  // difference sign is exact because no overflow is possible.
  assign is_eq  = (op1 == op2);
  assign is_ltu = borrow;
  assign is_lt  = (op1[WIDTH-1] ^ op2[WIDTH-1]) ? op1[WIDTH-1] : diff[WIDTH-1];

  // Map shift opcodes onto shifter modes; non-shift ops leave it idle on SLL.
  always_comb begin
    sh_mode = SH_SLL;
    if (codeop == OP_SRL) sh_mode = SH_SRL;
    else if (codeop == OP_SRA) sh_mode = SH_SRA;
  end

  lite16_alu_shifter #(
    .SW(WIDTH)
  ) u_shifter (
    .op1   (op1),
    .shamt (op2[$clog2(WIDTH)-1:0]),
    .mode  (sh_mode),
    .result(sh_result)
  );

  // Select next result and compare flag; load overrides everything else.
  always_comb begin
    r_next   = '0;
    cmp_next = 1'b0;
    if (ld) begin
      r_next = b;
    end else if (fn) begin
      r_next = diff;
      case (codeop)
        CC_EQ:     cmp_next = is_eq;
        CC_NE:     cmp_next = !is_eq;
        CC_LT:     cmp_next = is_lt;
        CC_GE:     cmp_next = !is_lt;
        CC_LTU:    cmp_next = is_ltu;
        CC_GEU:    cmp_next = !is_ltu;
        CC_ALWAYS: cmp_next = 1'b1;
        CC_NEVER:  cmp_next = 1'b0;
        default:   cmp_next = 1'b0;
      endcase
    end else begin
      case (codeop)
        OP_ADD:  r_next = sum;
        OP_SUB:  r_next = diff;
        OP_AND:  r_next = op1 & op2;
        OP_OR:   r_next = op1 | op2;
        OP_XOR:  r_next = op1 ^ op2;
        OP_SLL,
        OP_SRL,
        OP_SRA:  r_next = sh_result;
        default: r_next = '0;
      endcase
    end
  end

  // Output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_reg   <= '0;
      cmp_reg <= 1'b0;
    end else begin
      r_reg   <= r_next;
      cmp_reg <= cmp_next;
    end
  end

  assign r   = r_reg;
  assign cmp = cmp_reg;

endmodule

// File: tb/tb_lite16_alu.sv
// Directed testbench for lite16_alu: hand-computed vectors checked with
// immediate assertions one cycle after each stimulus.
module tb_lite16_alu;

  logic        clk;
  logic        rst_n;
  logic [2:0]  codeop;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] rd;
  logic        ri;
  logic        ld;
  logic        fn;
  logic [15:0] r;
  logic        cmp;

  int total;
  int bad;

  logic [15:0] exp_reg_form [8];
  logic [15:0] exp_imm_form [8];
  logic        exp_cmp_5_6  [8];

  lite16_alu #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .codeop(codeop),
    .a     (a),
    .b     (b),
    .rd    (rd),
    .ri    (ri),
    .ld    (ld),
    .fn    (fn),
    .r     (r),
    .cmp   (cmp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply the current inputs across one rising edge, then sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] exp_r, input logic exp_c);
    total++;
    assert (r === exp_r && cmp === exp_c)
    else begin
      bad++;
      $error("FAIL %s: got r=%h cmp=%b, want r=%h cmp=%b", tag, r, cmp, exp_r, exp_c);
    end
    $display("txn %s: r=%h cmp=%b", tag, r, cmp);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    exp_reg_form = '{16'h000D, 16'h0001, 16'h0006, 16'h0007,
                     16'h0001, 16'h01C0, 16'h0000, 16'h0000};
    exp_imm_form = '{16'h000B, 16'hFFFF, 16'h0004, 16'h0007,
                     16'h0003, 16'h0140, 16'h0000, 16'h0000};
    exp_cmp_5_6  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    // Reset with nonzero inputs present
    rst_n = 1'b0; codeop = 3'd0; a = 16'h0007; b = 16'h0006; rd = 16'h0005;
    ri = 1'b0; ld = 1'b0; fn = 1'b0;
    step();
    step();
    check("reset", 16'h0000, 1'b0);
    rst_n = 1'b1;

    // 1. Register form sweep
    for (int i = 0; i < 8; i++) begin
      codeop = i[2:0];
      step();
      check($sformatf("reg_op%0d", i), exp_reg_form[i], 1'b0);
    end

    // 2. Two-address form sweep
    ri = 1'b1;
    for (int i = 0; i < 8; i++) begin
      codeop = i[2:0];
      step();
      check($sformatf("imm_op%0d", i), exp_imm_form[i], 1'b0);
    end

    // 3. Compare sweep, op1=5 op2=6
    fn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      codeop = i[2:0];
      step();
      check($sformatf("cc%0d", i), 16'hFFFF, exp_cmp_5_6[i]);
    end

    // Signed versus unsigned ordering at the sign boundary
    ri = 1'b0; a = 16'h8000; b = 16'h7FFF;
    codeop = 3'd2; step(); check("lt_8000_7fff", 16'h0001, 1'b1);
    codeop = 3'd4; step(); check("ltu_8000_7fff", 16'h0001, 1'b0);

    // 4. Boundaries
    fn = 1'b0;
    codeop = 3'd0; a = 16'hFFFF; b = 16'h0001; step(); check("add_wrap", 16'h0000, 1'b0);
    codeop = 3'd7; a = 16'h8000; b = 16'h0001; step(); check("sra_sign", 16'hC000, 1'b0);
    codeop = 3'd5; a = 16'h1234; b = 16'h0010; step(); check("sll_sh0", 16'h1234, 1'b0);

    // 5. Load pass-through overrides compare
    ld = 1'b1; fn = 1'b1; codeop = 3'd0; b = 16'h1234; a = 16'h1234;
    step(); check("load", 16'h1234, 1'b0);

    // 6. Mid-sequence reset
    ld = 1'b0; fn = 1'b0; ri = 1'b0; codeop = 3'd0; a = 16'h0007; b = 16'h0006;
    step(); check("pre_rst", 16'h000D, 1'b0);
    rst_n = 1'b0;
    step(); check("mid_rst", 16'h0000, 1'b0);
    rst_n = 1'b1;
    step(); check("post_rst", 16'h000D, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
